mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Round-robin arbiter sharing one start/ready multiplier among NUM_REQ requesters
//  (e.g. several mult-add sequencers in the polynomial datapath). It latches the
//  winner's operands, pulses mult_start, waits for mult_result_ready and returns the
//  product to the owning requester. At most one multiply is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  NUM_REQ     4   number of requesters, >= 2
//  IDX_W       $clog2(NUM_REQ)  derived (localparam), owner index width
// PORTS
//  clock              in   1                   system clock, all logic on posedge
//  reset              in   1                   synchronous, active-high
//  req_valid          in   NUM_REQ             per-requester request, level
//  req_a              in   NUM_REQ*DATA_WIDTH  operand A, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//  req_b              in   NUM_REQ*DATA_WIDTH  operand B, same slicing
//  req_grant          out  NUM_REQ             one-hot 1-cycle pulse: operands accepted
//  resp_valid         out  NUM_REQ             one-hot 1-cycle pulse: resp_data is for that requester
//  resp_data          out  DATA_WIDTH          product, held until the next response
//  mult_a, mult_b     out  DATA_WIDTH          operands to the shared multiplier
//  mult_start         out  1                   1-cycle start pulse to the multiplier
//  mult_result        in   DATA_WIDTH          multiplier product
//  mult_result_ready  in   1                   multiplier done, 1-cycle pulse
//  busy               out  1                   1 while a multiply is outstanding (state WAIT)
//  owner              out  IDX_W               index of the current/last granted requester
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; last_owner = NUM_REQ-1, so requester 0 has top priority.
//  - All outputs are registered.
//  - FSM IDLE:
//    - If any req_valid is high at edge k, pick the first set bit searching circularly
//      from last_owner+1.
//    - In cycle k+1: req_grant[winner]=1, mult_a/mult_b = winner's slices,
//      mult_start=1, owner=winner, busy=1, state WAIT.
//    - If no req_valid is high, stay in IDLE.
//  - FSM WAIT:
//    - mult_start returns to 0 after one cycle; mult_a/mult_b are held.
//    - mult_result_ready is ignored in the first WAIT cycle (the one with mult_start=1).
//    - On ready at edge m, in cycle m+1: resp_data=mult_result, resp_valid[owner]=1,
//      last_owner=owner, busy=0, state IDLE.
//  - Latency: grant 1 cycle after request sampled; resp_valid 1 cycle after ready.
//    A new request can be sampled in the resp_valid cycle, so the back-to-back issue gap
//    is 1 cycle.
//  - req_valid is ignored in WAIT.
//  - Requester obligations:
//    - Hold req_a/req_b stable while req_valid is high.
//    - Drop req_valid in the cycle after req_grant.
//    - Dropping req_valid before being granted withdraws the request; no op is issued.
//  - mult_result_ready while IDLE is stale: discarded, no resp_valid, no state change.
//  - Round-robin pointer advances only on completion.
//    - With all requesters active, each is served once per NUM_REQ ops.
//    - No requester waits more than NUM_REQ-1 ops.
//  - Reset mid-operation (any state): return to the reset values in the next cycle.
//    The in-flight product is dropped; a later mult_result_ready is stale (IDLE rule).
//  - At most one bit of req_grant/resp_valid is ever set; no arithmetic done here
//    (product width = DATA_WIDTH, truncation is the multiplier's concern).
// TESTING
//  1. After reset, req_valid=4'b0100, a2=3, b2=5; model returns ready 4 cycles after start
//     -> req_grant=4'b0100 next cycle, single mult_start with mult_a=3, mult_b=5,
//        then resp_valid=4'b0100, resp_data=15.
//  2. All four requesters raise req_valid together after reset, each dropping it after
//     its grant -> grants in order 0,1,2,3, each with its own operands, 4 resp pulses.
//  3. Requesters 1 and 3 re-request immediately after every response for 6 ops
//     -> service order 1,3,1,3,1,3; requester 1 never served twice in a row.
//  4. Ready pulsed in IDLE, and ready coincident with the mult_start cycle
//     -> no resp_valid in either case; the correct ready 3 cycles later is accepted.
//  5. reset asserted for 1 cycle in WAIT, then the stale ready arrives
//     -> all outputs 0, no resp_valid; the next request from 3 and 0 grants 0 first.
//  6. req_valid[1] pulsed for 2 cycles while requester 0 is in WAIT, then dropped
//     -> requester 1 never granted; busy falls and the FSM idles.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one start/ready multiplier
// Grants one requester at a time, issues its operands and routes the product back.
module mult_share_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   localparam int IDX_W     = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            req_grant,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic [DATA_WIDTH-1:0]         mult_a,
   output logic [DATA_WIDTH-1:0]         mult_b,
   output logic                          mult_start,
   input  logic [DATA_WIDTH-1:0]         mult_result,
   input  logic                          mult_result_ready,
   output logic                          busy,
   output logic [IDX_W-1:0]              owner
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   state_t           state;
   logic [IDX_W-1:0] last_owner;
   logic [IDX_W-1:0] winner;

   // Circular search starting just after the last completed owner.
   always_comb begin
      int   idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_owner) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req_valid[IDX_W'(idx)]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= IDX_W'(NUM_REQ - 1);
         req_grant  <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         mult_a     <= '0;
         mult_b     <= '0;
         mult_start <= 1'b0;
         busy       <= 1'b0;
         owner      <= '0;
      end else begin
         req_grant  <= '0;
         resp_valid <= '0;
         mult_start <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  req_grant  <= ONE_HOT0 << winner;
                  mult_a     <= req_a[winner*DATA_WIDTH +: DATA_WIDTH];
                  mult_b     <= req_b[winner*DATA_WIDTH +: DATA_WIDTH];
                  mult_start <= 1'b1;
                  owner      <= winner;
                  busy       <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               // A ready coinciding with our own start pulse cannot belong to this op.
               if (mult_result_ready && !mult_start) begin
                  resp_data  <= mult_result;
                  resp_valid <= ONE_HOT0 << owner;
                  last_owner <= owner;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed and randomized checks of mult_share_arbiter
module tb_mult_share_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;

   logic             clock;
   logic             reset;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic [NR-1:0]    req_grant;
   logic [NR-1:0]    resp_valid;
   logic [DW-1:0]    resp_data;
   logic [DW-1:0]    mult_a;
   logic [DW-1:0]    mult_b;
   logic             mult_start;
   logic [DW-1:0]    mult_result;
   logic             mult_result_ready;
   logic             busy;
   logic [1:0]       owner;

   logic [DW-1:0] op_a [NR];
   logic [DW-1:0] op_b [NR];

   int checks;
   int failures;

   bit            auto_mult;
   bit            mm_rand;
   int            mm_lat;
   int            mm_cnt;
   logic [DW-1:0] mm_prod;

   mult_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_a             (req_a),
      .req_b             (req_b),
      .req_grant         (req_grant),
      .resp_valid        (resp_valid),
      .resp_data         (resp_data),
      .mult_a            (mult_a),
      .mult_b            (mult_b),
      .mult_start        (mult_start),
      .mult_result       (mult_result),
      .mult_result_ready (mult_result_ready),
      .busy              (busy),
      .owner             (owner)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NR; i++) begin
         req_a[i*DW +: DW] = op_a[i];
         req_b[i*DW +: DW] = op_b[i];
      end
   end

   // Behavioural multiplier: answers a start after a fixed or random number of cycles.
   initial begin
      mult_result_ready = 1'b0;
      mult_result       = '0;
      mm_cnt            = 0;
      mm_prod           = '0;
      forever begin
         @(posedge clock);
         #1;
         if (auto_mult) begin
            mult_result_ready = 1'b0;
            if (mm_cnt > 0) begin
               mm_cnt--;
               if (mm_cnt == 0) begin
                  mult_result_ready = 1'b1;
                  mult_result       = mm_prod;
               end
            end
            if (mult_start) begin
               mm_cnt  = mm_rand ? int'($urandom_range(1, 5)) : mm_lat;
               mm_prod = mult_a * mult_b;
            end
         end else begin
            mm_cnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      repeat (2) cyc();
      reset = 1'b0;
   endtask

   function automatic int pick(int last, logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++;
      if ({req_grant, resp_valid, resp_data, mult_a, mult_b, mult_start, busy, owner} !== '0) begin
         failures++;
         $display("FAIL reset_outputs grant=%b resp=%b data=%0d a=%0d b=%0d start=%b busy=%b owner=%0d exp all 0",
                  req_grant, resp_valid, resp_data, mult_a, mult_b, mult_start, busy, owner);
      end
      cyc();
      checks++;
      if ({req_grant, mult_start, busy} !== 3'b0) begin
         failures++;
         $display("FAIL reset_idle grant=%b start=%b busy=%b exp 0", req_grant, mult_start, busy);
      end
   endtask

   task automatic test_single();
      int n, starts;
      auto_mult = 1'b1;
      mm_rand   = 1'b0;
      mm_lat    = 4;
      do_reset();
      op_a[2]   = 32'd3;
      op_b[2]   = 32'd5;
      req_valid = 4'b0100;
      cyc();
      checks++;
      if ({req_grant, mult_start, busy, owner} !== {4'b0100, 1'b1, 1'b1, 2'd2}) begin
         failures++;
         $display("FAIL single_grant grant=%b start=%b busy=%b owner=%0d exp 0100 1 1 2",
                  req_grant, mult_start, busy, owner);
      end
      checks++;
      if (mult_a !== 32'd3 || mult_b !== 32'd5) begin
         failures++;
         $display("FAIL single_operands a=%0d b=%0d exp 3 5", mult_a, mult_b);
      end
      req_valid = '0;
      starts    = 1;
      n         = 0;
      while (resp_valid == '0 && n < 20) begin
         cyc();
         n++;
         if (mult_start) starts++;
      end
      checks++;
      if (resp_valid !== 4'b0100 || resp_data !== 32'd15) begin
         failures++;
         $display("FAIL single_resp resp=%b data=%0d exp 0100 15", resp_valid, resp_data);
      end
      checks++;
      if (n !== 5 || starts !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_timing cycles=%0d starts=%0d busy=%b exp 5 1 0", n, starts, busy);
      end
      cyc();
      checks++;
      if (resp_valid !== 4'b0 || resp_data !== 32'd15) begin
         failures++;
         $display("FAIL single_hold resp=%b data=%0d exp 0000 15", resp_valid, resp_data);
      end
   endtask

   task automatic test_all_four();
      int n;
      logic [NR-1:0] e;
      logic [DW-1:0] p;
      auto_mult = 1'b1;
      mm_rand   = 1'b1;
      do_reset();
      for (int i = 0; i < NR; i++) begin
         op_a[i] = $urandom;
         op_b[i] = $urandom;
      end
      req_valid = 4'b1111;
      for (int k = 0; k < NR; k++) begin
         e = 4'b0001 << k;
         p = op_a[k] * op_b[k];
         n = 0;
         do begin cyc(); n++; end while (req_grant == '0 && n < 30);
         checks++;
         if (req_grant !== e || mult_a !== op_a[k] || mult_b !== op_b[k]) begin
            failures++;
            $display("FAIL all4_grant op=%0d grant=%b a=%h b=%h exp %b %h %h",
                     k, req_grant, mult_a, mult_b, e, op_a[k], op_b[k]);
         end
         req_valid[k] = 1'b0;
         n = 0;
         do begin cyc(); n++; end while (resp_valid == '0 && n < 30);
         checks++;
         if (resp_valid !== e || resp_data !== p) begin
            failures++;
            $display("FAIL all4_resp op=%0d resp=%b data=%h exp %b %h", k, resp_valid, resp_data, e, p);
         end
      end
   endtask

   task automatic test_alternate();
      int n, w;
      logic [NR-1:0] e;
      logic [DW-1:0] p;
      auto_mult = 1'b1;
      mm_rand   = 1'b1;
      do_reset();
      op_a[1] = $urandom; op_b[1] = $urandom;
      op_a[3] = $urandom; op_b[3] = $urandom;
      req_valid = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         w = (k % 2 == 0) ? 1 : 3;
         e = 4'b0001 << w;
         p = op_a[w] * op_b[w];
         n = 0;
         do begin cyc(); n++; end while (req_grant == '0 && n < 30);
         checks++;
         if (req_grant !== e || mult_a !== op_a[w] || (k > 0 && n !== 1)) begin
            failures++;
            $display("FAIL alt_grant op=%0d grant=%b a=%h gap=%0d exp %b %h gap 1",
                     k, req_grant, mult_a, n, e, op_a[w]);
         end
         req_valid[w] = 1'b0;
         n = 0;
         do begin cyc(); n++; end while (resp_valid == '0 && n < 30);
         checks++;
         if (resp_valid !== e || resp_data !== p) begin
            failures++;
            $display("FAIL alt_resp op=%0d resp=%b data=%h exp %b %h", k, resp_valid, resp_data, e, p);
         end
         if (k < 4) begin
            op_a[w]      = $urandom;
            op_b[w]      = $urandom;
            req_valid[w] = 1'b1;
         end
      end
   endtask

   task automatic test_stale_ready();
      auto_mult         = 1'b0;
      mult_result_ready = 1'b0;
      do_reset();
      mult_result       = 32'd99;
      mult_result_ready = 1'b1;
      cyc();
      mult_result_ready = 1'b0;
      checks++;
      if (resp_valid !== 4'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stale_idle_a resp=%b busy=%b exp 0000 0", resp_valid, busy);
      end
      cyc();
      checks++;
      if (resp_valid !== 4'b0 || busy !== 1'b0 || req_grant !== 4'b0 || resp_data !== 32'd0) begin
         failures++;
         $display("FAIL stale_idle_b resp=%b busy=%b grant=%b data=%0d exp 0 0 0 0",
                  resp_valid, busy, req_grant, resp_data);
      end
      op_a[0]   = 32'd7;
      op_b[0]   = 32'd6;
      req_valid = 4'b0001;
      cyc();
      checks++;
      if (req_grant !== 4'b0001 || mult_start !== 1'b1) begin
         failures++;
         $display("FAIL stale_grant grant=%b start=%b exp 0001 1", req_grant, mult_start);
      end
      req_valid         = '0;
      mult_result       = 32'd111;
      mult_result_ready = 1'b1;
      cyc();
      mult_result_ready = 1'b0;
      checks++;
      if (resp_valid !== 4'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stale_start_ready resp=%b busy=%b exp 0000 1", resp_valid, busy);
      end
      cyc();
      cyc();
      mult_result       = 32'd42;
      mult_result_ready = 1'b1;
      cyc();
      mult_result_ready = 1'b0;
      checks++;
      if (resp_valid !== 4'b0001 || resp_data !== 32'd42 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stale_real_ready resp=%b data=%0d busy=%b exp 0001 42 0", resp_valid, resp_data, busy);
      end
   endtask

   task automatic test_reset_in_wait();
      auto_mult         = 1'b0;
      mult_result_ready = 1'b0;
      do_reset();
      op_a[2]   = 32'd9;
      op_b[2]   = 32'd4;
      req_valid = 4'b0100;
      cyc();
      req_valid = '0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks++;
      if ({req_grant, resp_valid, resp_data, mult_a, mult_b, mult_start, busy, owner} !== '0) begin
         failures++;
         $display("FAIL rstwait_outputs grant=%b resp=%b data=%0d a=%0d b=%0d start=%b busy=%b owner=%0d exp all 0",
                  req_grant, resp_valid, resp_data, mult_a, mult_b, mult_start, busy, owner);
      end
      mult_result       = 32'd36;
      mult_result_ready = 1'b1;
      cyc();
      mult_result_ready = 1'b0;
      checks++;
      if (resp_valid !== 4'b0 || busy !== 1'b0 || resp_data !== 32'd0) begin
         failures++;
         $display("FAIL rstwait_stale resp=%b busy=%b data=%0d exp 0000 0 0", resp_valid, busy, resp_data);
      end
      op_a[0]   = 32'd11; op_b[0] = 32'd2;
      op_a[3]   = 32'd13; op_b[3] = 32'd3;
      req_valid = 4'b1001;
      cyc();
      checks++;
      if (req_grant !== 4'b0001 || mult_a !== 32'd11 || owner !== 2'd0) begin
         failures++;
         $display("FAIL rstwait_first grant=%b a=%0d owner=%0d exp 0001 11 0", req_grant, mult_a, owner);
      end
      req_valid[0] = 1'b0;
      cyc();
      mult_result       = 32'd22;
      mult_result_ready = 1'b1;
      cyc();
      mult_result_ready = 1'b0;
      checks++;
      if (resp_valid !== 4'b0001 || resp_data !== 32'd22) begin
         failures++;
         $display("FAIL rstwait_resp0 resp=%b data=%0d exp 0001 22", resp_valid, resp_data);
      end
      cyc();
      checks++;
      if (req_grant !== 4'b1000 || mult_a !== 32'd13 || mult_b !== 32'd3) begin
         failures++;
         $display("FAIL rstwait_second grant=%b a=%0d b=%0d exp 1000 13 3", req_grant, mult_a, mult_b);
      end
      req_valid = '0;
      cyc();
      mult_result       = 32'd39;
      mult_result_ready = 1'b1;
      cyc();
      mult_result_ready = 1'b0;
      checks++;
      if (resp_valid !== 4'b1000 || resp_data !== 32'd39) begin
         failures++;
         $display("FAIL rstwait_resp3 resp=%b data=%0d exp 1000 39", resp_valid, resp_data);
      end
   endtask

   task automatic test_withdraw();
      int grants, resps;
      auto_mult = 1'b1;
      mm_rand   = 1'b0;
      mm_lat    = 6;
      do_reset();
      op_a[0]   = 32'd5; op_b[0] = 32'd8;
      op_a[1]   = 32'd1; op_b[1] = 32'd1;
      req_valid = 4'b0001;
      cyc();
      checks++;
      if (req_grant !== 4'b0001) begin
         failures++;
         $display("FAIL withdraw_grant0 grant=%b exp 0001", req_grant);
      end
      req_valid = 4'b0010;
      cyc();
      cyc();
      req_valid = '0;
      grants = 0;
      resps  = 0;
      for (int n = 0; n < 12; n++) begin
         cyc();
         if (req_grant != '0) grants++;
         if (resp_valid == 4'b0001 && resp_data == 32'd40) resps++;
      end
      checks++;
      if (grants !== 0 || resps !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL withdraw_idle grants=%0d resps=%0d busy=%b exp 0 1 0", grants, resps, busy);
      end
   endtask

   task automatic test_random();
      logic [NR-1:0] e_grant, e_resp;
      logic [DW-1:0] e_data, e_ma, e_mb;
      logic          e_start, e_busy, cur_start;
      logic [1:0]    e_owner;
      int            m_last, w;
      auto_mult = 1'b1;
      mm_rand   = 1'b1;
      do_reset();
      e_grant = '0; e_resp = '0; e_data = '0; e_ma = '0; e_mb = '0;
      e_start = 1'b0; e_busy = 1'b0; e_owner = '0; m_last = NR - 1;
      for (int c = 0; c < 400; c++) begin
         checks++;
         if ({req_grant, resp_valid, mult_start, busy} !== {e_grant, e_resp, e_start, e_busy}) begin
            failures++;
            $display("FAIL rand_ctrl cyc=%0d grant=%b resp=%b start=%b busy=%b exp %b %b %b %b",
                     c, req_grant, resp_valid, mult_start, busy, e_grant, e_resp, e_start, e_busy);
         end
         checks++;
         if (resp_data !== e_data || mult_a !== e_ma || mult_b !== e_mb || owner !== e_owner) begin
            failures++;
            $display("FAIL rand_data cyc=%0d data=%h a=%h b=%h owner=%0d exp %h %h %h %0d",
                     c, resp_data, mult_a, mult_b, owner, e_data, e_ma, e_mb, e_owner);
         end
         for (int i = 0; i < NR; i++) begin
            if (e_grant[i]) begin
               req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  op_a[i]      = $urandom;
                  op_b[i]      = $urandom;
                  req_valid[i] = 1'b1;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         cur_start = e_start;
         e_grant   = '0;
         e_resp    = '0;
         e_start   = 1'b0;
         if (!e_busy) begin
            if (req_valid != '0) begin
               w       = pick(m_last, req_valid);
               e_grant = 4'b0001 << w;
               e_start = 1'b1;
               e_busy  = 1'b1;
               e_owner = 2'(w);
               e_ma    = op_a[w];
               e_mb    = op_b[w];
            end
         end else if (mult_result_ready && !cur_start) begin
            e_resp = 4'b0001 << e_owner;
            e_data = e_ma * e_mb;
            m_last = int'(e_owner);
            e_busy = 1'b0;
         end
         cyc();
      end
      req_valid = '0;
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      reset             = 1'b1;
      req_valid         = '0;
      auto_mult         = 1'b1;
      mm_rand           = 1'b0;
      mm_lat            = 4;
      for (int i = 0; i < NR; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      test_reset();
      test_single();
      test_all_four();
      test_alternate();
      test_stale_ready();
      test_reset_in_wait();
      mult_result_ready = 1'b0;
      test_withdraw();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
